// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Multi-cycle MIPS control FSM with memory wait-states,
//               watchdog timeout and sticky fault state.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_EN = 1,
  parameter int TIMEOUT     = 15,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALU_Control,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State,
  output logic       Fault
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic             WAIT_EN   = (MEM_WAIT_EN != 0);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             mem_ok;
  logic             mem_state;
  logic             timeout_hit;
  logic             funct_ok;
  logic [2:0]       funct_alu;
  logic             pc_write;
  logic             branch;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (Funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  assign mem_ok      = !WAIT_EN || MemReady;
  assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // A ready in the final allowed wait cycle takes precedence over the timeout.
  assign timeout_hit = !mem_ok && (cnt == LAST_WAIT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!WAIT_EN || !mem_state || mem_ok || timeout_hit) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end

    case (state)
      S_FETCH:  state_next = mem_ok ? S_DECODE : (timeout_hit ? S_FAULT : S_FETCH);
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = funct_ok ? S_EXEC : S_FAULT;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FAULT;
        endcase
      end
      S_MEMADR: state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next = mem_ok ? S_MEMWB : (timeout_hit ? S_FAULT : S_MEMRD);
      S_MEMWR:  state_next = mem_ok ? S_FETCH : (timeout_hit ? S_FAULT : S_MEMWR);
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: state_next = S_FETCH;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FAULT;
    endcase
  end

  always_comb begin
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALU_Control = ALU_ADD;
    PCSrc       = 2'b00;
    pc_write    = 1'b0;
    branch      = 1'b0;
    // Gating on RST keeps the reset state (FETCH) from issuing a memory read.
    if (RST) begin
      case (state)
        S_FETCH: begin
          MemRead  = 1'b1;
          ALUSrcB  = 2'b01;
          IRWrite  = mem_ok;
          pc_write = mem_ok;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA     = 1'b1;
          ALU_Control = funct_alu;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALU_Control = ALU_SUB;
          PCSrc       = 2'b01;
          branch      = 1'b1;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PCSrc    = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
    PCEn = pc_write | (branch & Zero);
  end

  assign State = state;
  assign Fault = (state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed self-checking bench for mips_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_Control;
  logic       PCEn, Fault;
  logic [3:0] State;

  int tests = 0;
  int failed = 0;

  mips_multicycle_ctrl #(.MEM_WAIT_EN(1), .TIMEOUT(15), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control),
    .PCSrc(PCSrc), .PCEn(PCEn), .State(State), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // en order: {MemRead, MemWrite, IRWrite, RegWrite, PCEn}
  task automatic st(input string tag, input logic [3:0] s, input logic [4:0] en);
    chk({tag, ".state"}, {4'd0, State}, {4'd0, s});
    chk({tag, ".en"}, {3'd0, MemRead, MemWrite, IRWrite, RegWrite, PCEn}, {3'd0, en});
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    #1;
    st("rst", 4'd0, 5'b00000);
    chk("rst.fault", {7'd0, Fault}, 8'd0);
    chk("rst.alu", {5'd0, ALU_Control}, 8'h02);
    chk("rst.sel", {2'd0, IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB}, 8'd0);
    chk("rst.pcsrc", {6'd0, PCSrc}, 8'd0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
  endtask

  initial begin
    #3;
    do_reset();

    // LW, memory always ready
    Opcode = 6'b100011; MemReady = 1'b1;
    st("lw.fetch", 4'd0, 5'b10101);
    chk("lw.fetch.srcb", {6'd0, ALUSrcB}, 8'd1);
    chk("lw.fetch.alu", {5'd0, ALU_Control}, 8'h02);
    tick(); st("lw.decode", 4'd1, 5'b00000);
    chk("lw.decode.srcb", {6'd0, ALUSrcB}, 8'd3);
    tick(); st("lw.memadr", 4'd2, 5'b00000);
    chk("lw.memadr.src", {5'd0, ALUSrcA, ALUSrcB}, 8'b110);
    tick(); st("lw.memrd", 4'd3, 5'b10000);
    chk("lw.memrd.iord", {7'd0, IorD}, 8'd1);
    tick(); st("lw.memwb", 4'd4, 5'b00010);
    chk("lw.memwb.m2r", {6'd0, RegDst, MemtoReg}, 8'b01);
    tick(); st("lw.done", 4'd0, 5'b10101);

    // R-type add
    Opcode = 6'b000000; Funct = 6'b100000;
    tick(); st("radd.decode", 4'd1, 5'b00000);
    tick(); st("radd.exec", 4'd6, 5'b00000);
    chk("radd.exec.alu", {5'd0, ALU_Control}, 8'h02);
    chk("radd.exec.src", {5'd0, ALUSrcA, ALUSrcB}, 8'b100);
    tick(); st("radd.aluwb", 4'd7, 5'b00010);
    chk("radd.aluwb.dst", {6'd0, RegDst, MemtoReg}, 8'b10);
    tick(); st("radd.done", 4'd0, 5'b10101);

    // R-type slt
    Funct = 6'b101010;
    tick(); tick(); st("rslt.exec", 4'd6, 5'b00000);
    chk("rslt.exec.alu", {5'd0, ALU_Control}, 8'h07);
    tick(); tick(); st("rslt.done", 4'd0, 5'b10101);

    // SW
    Opcode = 6'b101011;
    tick(); st("sw.decode", 4'd1, 5'b00000);
    tick(); st("sw.memadr", 4'd2, 5'b00000);
    tick(); st("sw.memwr", 4'd5, 5'b01000);
    chk("sw.memwr.iord", {7'd0, IorD}, 8'd1);
    tick(); st("sw.done", 4'd0, 5'b10101);

    // BEQ taken
    Opcode = 6'b000100; Zero = 1'b1;
    tick(); tick(); st("beq1.beq", 4'd8, 5'b00001);
    chk("beq1.pcsrc", {6'd0, PCSrc}, 8'd1);
    chk("beq1.alu", {5'd0, ALU_Control}, 8'h06);
    // BEQ not taken
    Zero = 1'b0;
    tick(); tick(); tick(); st("beq0.beq", 4'd8, 5'b00000);
    tick(); st("beq0.done", 4'd0, 5'b10101);

    // J
    Opcode = 6'b000010;
    tick(); tick(); st("j.jump", 4'd11, 5'b00001);
    chk("j.pcsrc", {6'd0, PCSrc}, 8'd2);
    tick(); st("j.done", 4'd0, 5'b10101);

    // FETCH wait states then ADDI
    Opcode = 6'b001000; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 st("fwait", 4'd0, 5'b10000);
      tick();
    end
    MemReady = 1'b1;
    #1 st("fwait.ready", 4'd0, 5'b10101);
    tick(); st("addi.decode", 4'd1, 5'b00000);
    tick(); st("addi.ex", 4'd9, 5'b00000);
    chk("addi.ex.src", {5'd0, ALUSrcA, ALUSrcB}, 8'b110);
    tick(); st("addi.wb", 4'd10, 5'b00010);
    chk("addi.wb.dst", {6'd0, RegDst, MemtoReg}, 8'b00);
    tick(); st("addi.done", 4'd0, 5'b10101);

    // LW: ready arrives in the last allowed wait cycle -> advance
    Opcode = 6'b100011;
    tick(); tick(); tick();
    MemReady = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1 st("lastwait", 4'd3, 5'b10000);
      tick();
    end
    MemReady = 1'b1;
    #1 st("lastwait.ready", 4'd3, 5'b10000);
    tick(); st("lastwait.memwb", 4'd4, 5'b00010);
    tick(); st("lastwait.done", 4'd0, 5'b10101);

    // LW: MemReady held low in MEMRD -> FAULT after 15 wait cycles
    tick(); tick(); tick();
    MemReady = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1 st("timeout.wait", 4'd3, 5'b10000);
      tick();
    end
    st("timeout.fault", 4'd15, 5'b00000);
    chk("timeout.flag", {7'd0, Fault}, 8'd1);
    MemReady = 1'b1;
    tick(); tick();
    st("timeout.sticky", 4'd15, 5'b00000);
    chk("timeout.sticky.flag", {7'd0, Fault}, 8'd1);
    do_reset();
    st("timeout.restart", 4'd0, 5'b10101);

    // Illegal opcode
    Opcode = 6'b111111;
    tick(); st("badop.decode", 4'd1, 5'b00000);
    tick(); st("badop.fault", 4'd15, 5'b00000);
    chk("badop.flag", {7'd0, Fault}, 8'd1);
    do_reset();

    // Unsupported funct
    Opcode = 6'b000000; Funct = 6'b000000;
    tick(); tick(); st("badfn.fault", 4'd15, 5'b00000);
    do_reset();

    // Reset asserted during a held MEMWR
    Opcode = 6'b101011;
    tick(); tick(); tick();
    MemReady = 1'b0;
    #1 st("swrst.memwr", 4'd5, 5'b01000);
    RST = 1'b0;
    #1 st("swrst.abort", 4'd0, 5'b00000);
    @(negedge CLK);
    MemReady = 1'b1;
    RST = 1'b1;
    #1 st("swrst.restart", 4'd0, 5'b10101);
    tick(); st("swrst.decode", 4'd1, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
